// File: rtl/mcu_pwrseq_const_pkg.sv
// mcu_pwrseq_const_pkg: state encodings and default PLL lock timeout shared by the power sequencer
package mcu_pwrseq_const_pkg;
  typedef enum logic [2:0] {RUN, HOLD, PREQ, LOWPWR, PWAKE, RELEASE} pwr_state_t;
  localparam int LOCK_TIMEOUT_DEF = 1023;
  localparam int CNT_W = 10;
endpackage

// File: rtl/cdc_capt_sync.sv
// cdc_capt_sync: two-flop synchroniser for a level signal into the clk domain
module cdc_capt_sync (
  input  logic clk,
  input  logic nreset,
  input  logic async_i,
  output logic sync_o
);
  logic meta;
  // shift the asynchronous level through two flops
  always_ff @(posedge clk or negedge nreset)
    if (!nreset) {sync_o, meta} <= 2'b00;
    else {sync_o, meta} <= {meta, async_i};
endmodule

// File: rtl/mcu_pwr_seq.sv
// mcu_pwr_seq: deep-sleep entry/exit sequencer (hold, stop/standby handshake, PLL relock); MCU_PWRSEQ_LOCK_TIMEOUT_EN adds the lock timeout
module mcu_pwr_seq
  import mcu_pwrseq_const_pkg::*;
#(
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
  input  logic HCLK,
  input  logic HRESETn,
  input  logic PMUENABLE,
  input  logic SLEEPING,
  input  logic SLEEPDEEP,
  input  logic PDDS_REG,
  input  logic PLLON_REG,
  input  logic WAKEUP,
  input  logic PLL_LOCK,
  output logic SLEEPHOLDREQn,
  input  logic SLEEPHOLDACKn,
  output logic STOPREQ,
  input  logic STOPACK,
  output logic STBYREQ,
  input  logic STBYACK,
  output logic PLL_EN,
  output logic CLK_SEL,
  output logic LOCK_ERR,
  input  logic LOCK_ERR_CLR
);
  pwr_state_t state, state_d;
  logic pdds_q, pdds_d, pllon_q, pllon_d;
  logic hreq_d, stop_d, stby_d, pll_d, sel_d;
  logic wake_s, lock_s, tmo;
  cdc_capt_sync u_wake_sync (.clk(HCLK), .nreset(HRESETn), .async_i(WAKEUP), .sync_o(wake_s));
  cdc_capt_sync u_lock_sync (.clk(HCLK), .nreset(HRESETn), .async_i(PLL_LOCK), .sync_o(lock_s));
`ifdef MCU_PWRSEQ_LOCK_TIMEOUT_EN
  logic [CNT_W-1:0] cnt;
  assign tmo = (state == PWAKE) & pllon_q & ~lock_s & (cnt == CNT_W'(LOCK_TIMEOUT - 1));
  // count cycles spent waiting for lock; cleared whenever PWAKE is not continuing
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) cnt <= '0;
    else cnt <= (state == PWAKE && state_d == PWAKE) ? cnt + 1'b1 : '0;
  // sticky timeout flag; a timeout in the same cycle as a clear keeps the flag set
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) LOCK_ERR <= 1'b0;
    else LOCK_ERR <= tmo ? 1'b1 : LOCK_ERR_CLR ? 1'b0 : LOCK_ERR;
`else
  logic unused_ok;
  assign tmo = 1'b0;
  assign LOCK_ERR = 1'b0;
  assign unused_ok = LOCK_ERR_CLR & (LOCK_TIMEOUT != 0);
`endif
  // state, latched entry configuration and registered handshake/clock outputs
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state <= RUN;
      {pdds_q, pllon_q} <= 2'b00;
      {SLEEPHOLDREQn, STOPREQ, STBYREQ, PLL_EN, CLK_SEL} <= 5'b10000;
    end else begin
      state <= state_d;
      {pdds_q, pllon_q} <= {pdds_d, pllon_d};
      {SLEEPHOLDREQn, STOPREQ, STBYREQ, PLL_EN, CLK_SEL} <= {hreq_d, stop_d, stby_d, pll_d, sel_d};
    end
  // next state and next output values; outputs hold unless a transition changes them
  always_comb begin
    state_d = state;
    {pdds_d, pllon_d} = {pdds_q, pllon_q};
    {hreq_d, stop_d, stby_d, pll_d, sel_d} = {SLEEPHOLDREQn, STOPREQ, STBYREQ, PLL_EN, CLK_SEL};
    case (state)
      RUN: if (PMUENABLE & SLEEPING & SLEEPDEEP) begin
        state_d = HOLD;
        {pdds_d, pllon_d} = {PDDS_REG, PLLON_REG};
        hreq_d = 1'b0;
      end
      HOLD: if (!SLEEPHOLDACKn) begin
        state_d = PREQ;
        {sel_d, pll_d} = 2'b00;
        {stop_d, stby_d} = {~pdds_q, pdds_q};
      end else if (wake_s | ~SLEEPING) begin
        state_d = RELEASE;
        hreq_d = 1'b1;
      end
      PREQ: if (pdds_q ? STBYACK : STOPACK) state_d = LOWPWR;
      LOWPWR: if (wake_s) begin
        state_d = PWAKE;
        {stop_d, stby_d} = 2'b00;
        pll_d = pllon_q;
      end
      PWAKE: if (!pllon_q || lock_s || tmo) begin
        state_d = RELEASE;
        hreq_d = 1'b1;
        sel_d = pllon_q & lock_s;
        pll_d = pllon_q & ~tmo;
      end
      RELEASE: if (SLEEPHOLDACKn) state_d = RUN;
      default: state_d = RUN;
    endcase
  end
endmodule

// File: tb/tb_mcu_pwr_seq.sv
// tb_mcu_pwr_seq: randomized sleep/wake scenarios checked against a sequence-level model of the power sequencer
module tb_mcu_pwr_seq;
  logic HCLK = 0, HRESETn = 0, PMUENABLE = 0, SLEEPING = 0, SLEEPDEEP = 0, PDDS_REG = 0, PLLON_REG = 0;
  logic WAKEUP = 0, PLL_LOCK = 0, SLEEPHOLDACKn = 1, STOPACK = 0, STBYACK = 0, LOCK_ERR_CLR = 0;
  logic SLEEPHOLDREQn, STOPREQ, STBYREQ, PLL_EN, CLK_SEL, LOCK_ERR;
  logic [5:0] outs;
  logic exp_sel = 0, exp_err = 0;
  int tests = 0, fails = 0;
  always #5 HCLK = ~HCLK;
  assign outs = {SLEEPHOLDREQn, STOPREQ, STBYREQ, PLL_EN, CLK_SEL, LOCK_ERR};
  mcu_pwr_seq #(.LOCK_TIMEOUT(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PMUENABLE(PMUENABLE), .SLEEPING(SLEEPING), .SLEEPDEEP(SLEEPDEEP),
    .PDDS_REG(PDDS_REG), .PLLON_REG(PLLON_REG), .WAKEUP(WAKEUP), .PLL_LOCK(PLL_LOCK),
    .SLEEPHOLDREQn(SLEEPHOLDREQn), .SLEEPHOLDACKn(SLEEPHOLDACKn), .STOPREQ(STOPREQ), .STOPACK(STOPACK),
    .STBYREQ(STBYREQ), .STBYACK(STBYACK), .PLL_EN(PLL_EN), .CLK_SEL(CLK_SEL), .LOCK_ERR(LOCK_ERR),
    .LOCK_ERR_CLR(LOCK_ERR_CLR)
  );
  task automatic cyc(input int n);
    repeat (n) @(negedge HCLK);
  endtask
  task automatic test_reset;
    HRESETn = 0;
    cyc(2);
    tests++;
    if (outs !== 6'b100000) begin fails++; $display("FAIL reset_hold: got %b want 100000", outs); end
    HRESETn = 1;
    cyc(3);
    tests++;
    if (outs !== 6'b100000) begin fails++; $display("FAIL reset_idle: got %b want 100000", outs); end
  endtask
  task automatic test_cycle(input logic pdds, input logic pllon, input int ackd, input int pack, input logic early, input int lockd);
    logic [1:0] rq;
    int n;
    rq = pdds ? 2'b01 : 2'b10;
    PMUENABLE = 1; PDDS_REG = pdds; PLLON_REG = pllon; SLEEPING = 1; SLEEPDEEP = 1; PLL_LOCK = 0;
    cyc(1);
    PDDS_REG = ~pdds; PLLON_REG = ~pllon;
    tests++;
    if ({SLEEPHOLDREQn, STOPREQ, STBYREQ, CLK_SEL} !== {3'b000, exp_sel}) begin
      fails++; $display("FAIL hold_entry: got %b want %b", {SLEEPHOLDREQn, STOPREQ, STBYREQ, CLK_SEL}, {3'b000, exp_sel});
    end
    cyc(ackd);
    SLEEPHOLDACKn = 0;
    cyc(1);
    exp_sel = 0;
    tests++;
    if ({STOPREQ, STBYREQ, PLL_EN, CLK_SEL} !== {rq, 2'b00}) begin
      fails++; $display("FAIL preq_entry: got %b want %b", {STOPREQ, STBYREQ, PLL_EN, CLK_SEL}, {rq, 2'b00});
    end
    if (early) begin WAKEUP = 1; SLEEPING = 0; end
    for (int i = 0; i < pack; i++) begin
      cyc(1);
      tests++;
      if ({STOPREQ, STBYREQ} !== rq) begin fails++; $display("FAIL req_hold: got %b want %b", {STOPREQ, STBYREQ}, rq); end
    end
    if (pdds) STBYACK = 1; else STOPACK = 1;
    cyc(1);
    tests++;
    if ({STOPREQ, STBYREQ} !== rq) begin fails++; $display("FAIL lowpwr_req: got %b want %b", {STOPREQ, STBYREQ}, rq); end
    if (!early) begin cyc($urandom_range(0, 3)); WAKEUP = 1; SLEEPING = 0; end
    n = 0;
    while ({STOPREQ, STBYREQ} !== 2'b00 && n < 10) begin cyc(1); n++; end
    tests++;
    if (n != (early ? 1 : 3)) begin fails++; $display("FAIL req_drop: got %0d cycles want %0d", n, early ? 1 : 3); end
    STOPACK = 0; STBYACK = 0;
    tests++;
    if ({SLEEPHOLDREQn, PLL_EN, CLK_SEL} !== {1'b0, pllon, 1'b0}) begin
      fails++; $display("FAIL pwake_entry: got %b want %b", {SLEEPHOLDREQn, PLL_EN, CLK_SEL}, {1'b0, pllon, 1'b0});
    end
    if (pllon) begin
      for (int i = 0; i < lockd; i++) begin
        cyc(1);
        tests++;
        if ({SLEEPHOLDREQn, PLL_EN, CLK_SEL, LOCK_ERR} !== {3'b010, exp_err}) begin
          fails++; $display("FAIL lock_wait: got %b want %b", {SLEEPHOLDREQn, PLL_EN, CLK_SEL, LOCK_ERR}, {3'b010, exp_err});
        end
      end
      PLL_LOCK = 1;
    end
    n = 0;
    while (SLEEPHOLDREQn !== 1'b1 && n < 10) begin cyc(1); n++; end
    tests++;
    if (n != (pllon ? 3 : 1)) begin fails++; $display("FAIL release_lat: got %0d cycles want %0d", n, pllon ? 3 : 1); end
    exp_sel = pllon;
    tests++;
    if ({PLL_EN, CLK_SEL, STOPREQ, STBYREQ} !== {pllon, pllon, 2'b00}) begin
      fails++; $display("FAIL release_clk: got %b want %b", {PLL_EN, CLK_SEL, STOPREQ, STBYREQ}, {pllon, pllon, 2'b00});
    end
    SLEEPHOLDACKn = 1; WAKEUP = 0;
    cyc(3);
    tests++;
    if (outs !== {3'b100, pllon, pllon, exp_err}) begin fails++; $display("FAIL run_idle: got %b want %b", outs, {3'b100, pllon, pllon, exp_err}); end
  endtask
  task automatic test_abort(input logic use_wake);
    int n;
    logic seen;
    seen = 0;
    PMUENABLE = 1; PDDS_REG = 1'($urandom_range(0, 1)); PLLON_REG = 1; SLEEPING = 1; SLEEPDEEP = 1;
    cyc(1);
    tests++;
    if (SLEEPHOLDREQn !== 1'b0) begin fails++; $display("FAIL abort_hold: got %b want 0", SLEEPHOLDREQn); end
    if (use_wake) WAKEUP = 1; else SLEEPING = 0;
    n = 0;
    while (SLEEPHOLDREQn !== 1'b1 && n < 10) begin cyc(1); n++; seen |= STOPREQ | STBYREQ; end
    SLEEPING = 0; WAKEUP = 0;
    tests++;
    if (n != (use_wake ? 3 : 1)) begin fails++; $display("FAIL abort_lat: got %0d cycles want %0d", n, use_wake ? 3 : 1); end
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      seen |= STOPREQ | STBYREQ;
    end
    tests++;
    if ({seen, outs} !== {4'b0100, exp_sel, exp_sel, exp_err}) begin
      fails++; $display("FAIL abort_run: got %b want %b", {seen, outs}, {4'b0100, exp_sel, exp_sel, exp_err});
    end
  endtask
`ifdef MCU_PWRSEQ_LOCK_TIMEOUT_EN
  task automatic test_timeout(input logic hold_clr);
    int n;
    PMUENABLE = 1; PDDS_REG = 1'($urandom_range(0, 1)); PLLON_REG = 1; SLEEPING = 1; SLEEPDEEP = 1; PLL_LOCK = 0;
    cyc(1);
    SLEEPHOLDACKn = 0;
    cyc(1);
    STOPACK = 1; STBYACK = 1; WAKEUP = 1; SLEEPING = 0;
    n = 0;
    while (PLL_EN !== 1'b1 && n < 10) begin cyc(1); n++; end
    STOPACK = 0; STBYACK = 0; LOCK_ERR_CLR = hold_clr;
    tests++;
    if ({SLEEPHOLDREQn, STOPREQ, STBYREQ, PLL_EN} !== 4'b0001) begin
      fails++; $display("FAIL tmo_pwake: got %b want 0001", {SLEEPHOLDREQn, STOPREQ, STBYREQ, PLL_EN});
    end
    for (int i = 1; i < 8; i++) begin
      cyc(1);
      tests++;
      if ({LOCK_ERR, PLL_EN} !== 2'b01) begin fails++; $display("FAIL tmo_early: cycle %0d got %b want 01", i, {LOCK_ERR, PLL_EN}); end
    end
    cyc(1);
    tests++;
    if ({SLEEPHOLDREQn, PLL_EN, CLK_SEL, LOCK_ERR} !== 4'b1001) begin
      fails++; $display("FAIL tmo_set: got %b want 1001", {SLEEPHOLDREQn, PLL_EN, CLK_SEL, LOCK_ERR});
    end
    SLEEPHOLDACKn = 1; WAKEUP = 0;
    exp_sel = 0;
    if (hold_clr) begin
      cyc(1);
      LOCK_ERR_CLR = 0;
      tests++;
      if (LOCK_ERR !== 1'b0) begin fails++; $display("FAIL tmo_clr_after_set: got %b want 0", LOCK_ERR); end
    end else begin
      cyc(3);
      tests++;
      if (LOCK_ERR !== 1'b1) begin fails++; $display("FAIL tmo_sticky: got %b want 1", LOCK_ERR); end
      LOCK_ERR_CLR = 1;
      cyc(1);
      LOCK_ERR_CLR = 0;
      tests++;
      if (LOCK_ERR !== 1'b0) begin fails++; $display("FAIL tmo_clr: got %b want 0", LOCK_ERR); end
    end
    cyc(2);
    tests++;
    if (outs !== 6'b100000) begin fails++; $display("FAIL tmo_run: got %b want 100000", outs); end
  endtask
`endif
  task automatic test_reset_lowpwr;
    PMUENABLE = 1; PDDS_REG = 1; PLLON_REG = 1; SLEEPING = 1; SLEEPDEEP = 1;
    cyc(1);
    SLEEPHOLDACKn = 0;
    cyc(1);
    WAKEUP = 1;
    cyc(3);
    tests++;
    if ({STOPREQ, STBYREQ} !== 2'b01) begin fails++; $display("FAIL stby_hold_wake: got %b want 01", {STOPREQ, STBYREQ}); end
    STBYACK = 1;
    cyc(1);
    WAKEUP = 0;
    #2 HRESETn = 0;
    #1;
    tests++;
    if (outs !== 6'b100000) begin fails++; $display("FAIL reset_lowpwr: got %b want 100000", outs); end
    cyc(1);
    STBYACK = 0; SLEEPHOLDACKn = 1; SLEEPING = 0;
    HRESETn = 1;
    exp_sel = 0; exp_err = 0;
    cyc(3);
    tests++;
    if (outs !== 6'b100000) begin fails++; $display("FAIL reset_release: got %b want 100000", outs); end
  endtask
  initial begin
    test_reset;
    test_cycle(0, 1, 2, 3, 0, 5);
    test_abort(1);
    for (int k = 0; k < 8; k++)
      test_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 int'($urandom_range(2, 5)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
    test_cycle(1, 1, 1, 2, 1, 3);
    test_abort(0);
`ifdef MCU_PWRSEQ_LOCK_TIMEOUT_EN
    test_timeout(0);
    test_timeout(1);
`else
    test_cycle(0, 1, 1, 2, 0, 40);
`endif
    test_reset_lowpwr;
    test_cycle(1, 0, 0, 2, 0, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
